// File: rtl/mem_wb_pipe_stage_if.sv
// MEM->WB stage bus: upstream entry handshake, downstream writeback handshake,
// flush control and occupancy status.
interface mem_wb_pipe_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [XLEN-1:0]       in_alu;
    logic [XLEN-1:0]       in_mem;
    logic [REG_ADDR_W-1:0] in_rd;
    logic                  in_regwrite;
    logic                  in_memtoreg;
    logic                  out_valid;
    logic                  out_ready;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_regwrite;
    logic [XLEN-1:0]       out_wb_data;
    logic [1:0]            occ;

    modport master (
        output flush,
        output in_valid,
        output in_alu,
        output in_mem,
        output in_rd,
        output in_regwrite,
        output in_memtoreg,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_rd,
        input  out_regwrite,
        input  out_wb_data,
        input  occ
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  in_alu,
        input  in_mem,
        input  in_rd,
        input  in_regwrite,
        input  in_memtoreg,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_rd,
        output out_regwrite,
        output out_wb_data,
        output occ
    );
endinterface

// File: rtl/mem_wb_pipe_stage.sv
// Stallable, flushable MEM->WB pipeline stage with optional 2-entry skid buffer.
// The head entry drives the RF write port; bubbles and x0 never write.
module mem_wb_pipe_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit SKID_EN    = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    mem_wb_pipe_stage_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]       alu;
        logic [XLEN-1:0]       mem;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memtoreg;
    } entry_t;

    state_t state;
    state_t state_nxt;

    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;

    logic in_fire;
    logic out_fire;
    logic in_ready_int;
    logic out_valid_int;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid;

    assign in_entry = '{
        alu:      bus.in_alu,
        mem:      bus.in_mem,
        rd:       bus.in_rd,
        regwrite: bus.in_regwrite,
        memtoreg: bus.in_memtoreg
    };

    // Acceptance: skid build decodes purely from state, otherwise look through out_ready.
    generate
        if (SKID_EN) begin : g_rdy_skid
            assign in_ready_int = (state != FULL);
        end else begin : g_rdy_flow
            assign in_ready_int = (state == EMPTY) | bus.out_ready;
        end
    endgenerate

    assign out_valid_int = (state != EMPTY);
    assign in_fire       = bus.in_valid & in_ready_int;
    assign out_fire      = out_valid_int & bus.out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and payload load controls; flush overrides everything.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (bus.flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt    = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire && SKID_EN) begin
                        state_nxt = FULL;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_nxt      = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Head and skid payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_entry;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    // Occupancy decode.
    always_comb begin
        bus.occ = 2'd0;
        unique case (state)
            EMPTY:   bus.occ = 2'd0;
            ONE:     bus.occ = 2'd1;
            FULL:    bus.occ = 2'd2;
            default: bus.occ = 2'd0;
        endcase
    end

    assign bus.in_ready     = in_ready_int;
    assign bus.out_valid    = out_valid_int;
    assign bus.out_rd       = main_q.rd;
    assign bus.out_wb_data  = main_q.memtoreg ? main_q.mem : main_q.alu;
    assign bus.out_regwrite = out_valid_int & main_q.regwrite
                            & (main_q.rd != '0);

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Bench for mem_wb_pipe_stage: skid (side 1) and flow-through (side 0) builds,
// each checked against an in-order queue of expected writebacks.
module tb_mem_wb_pipe_stage;

    localparam int XLEN = 32;
    localparam int RAW  = 5;

    typedef struct packed {
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mem_wb_pipe_stage_if #(.XLEN(XLEN), .REG_ADDR_W(RAW)) b0 ();
    mem_wb_pipe_stage_if #(.XLEN(XLEN), .REG_ADDR_W(RAW)) b1 ();

    logic        iv   [2];
    logic [31:0] ia   [2];
    logic [31:0] im   [2];
    logic [4:0]  ird  [2];
    logic        irw  [2];
    logic        imr  [2];
    logic        ordy [2];
    logic        fl   [2];

    assign b0.in_valid    = iv[0];
    assign b0.in_alu      = ia[0];
    assign b0.in_mem      = im[0];
    assign b0.in_rd       = ird[0];
    assign b0.in_regwrite = irw[0];
    assign b0.in_memtoreg = imr[0];
    assign b0.out_ready   = ordy[0];
    assign b0.flush       = fl[0];

    assign b1.in_valid    = iv[1];
    assign b1.in_alu      = ia[1];
    assign b1.in_mem      = im[1];
    assign b1.in_rd       = ird[1];
    assign b1.in_regwrite = irw[1];
    assign b1.in_memtoreg = imr[1];
    assign b1.out_ready   = ordy[1];
    assign b1.flush       = fl[1];

    mem_wb_pipe_stage #(.XLEN(XLEN), .REG_ADDR_W(RAW), .SKID_EN(1'b0)) u_flow (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    mem_wb_pipe_stage #(.XLEN(XLEN), .REG_ADDR_W(RAW), .SKID_EN(1'b1)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    int   tests = 0;
    int   fails = 0;
    exp_t q [2][$];
    exp_t stim [2];

    logic        s_ov  [2];
    logic        s_ir  [2];
    logic        s_rw  [2];
    logic [31:0] s_wb  [2];
    logic [4:0]  s_rd  [2];
    logic [1:0]  s_occ [2];

    task automatic chk(input string nm, input int s,
                       input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s side%0d t=%0t got %h want %h", nm, s, $time, act, req);
        end
    endtask

    // Monitor: mid-cycle sample, compare against the expected queue, then advance it.
    always @(negedge clk) begin
        s_ov[0] = b0.out_valid;    s_ov[1] = b1.out_valid;
        s_ir[0] = b0.in_ready;     s_ir[1] = b1.in_ready;
        s_rw[0] = b0.out_regwrite; s_rw[1] = b1.out_regwrite;
        s_wb[0] = b0.out_wb_data;  s_wb[1] = b1.out_wb_data;
        s_rd[0] = b0.out_rd;       s_rd[1] = b1.out_rd;
        s_occ[0] = b0.occ;         s_occ[1] = b1.occ;
        for (int s = 0; s < 2; s++) begin
            if (!rst_n) begin
                chk("rst_valid", s, 32'(s_ov[s]), 32'd0);
                chk("rst_occ", s, 32'(s_occ[s]), 32'd0);
                chk("rst_wb", s, s_wb[s], 32'd0);
                chk("rst_rd", s, 32'(s_rd[s]), 32'd0);
                chk("rst_rw", s, 32'(s_rw[s]), 32'd0);
                chk("rst_ready", s, 32'(s_ir[s]), 32'd1);
                q[s].delete();
            end else begin
                logic exp_ir;
                int   n;
                n = q[s].size();
                exp_ir = (s == 1) ? (n < 2) : ((n == 0) || ordy[s]);
                chk("in_ready", s, 32'(s_ir[s]), 32'(exp_ir));
                chk("occ", s, 32'(s_occ[s]), 32'(n));
                chk("out_valid", s, 32'(s_ov[s]), 32'(n > 0));
                if (n > 0) begin
                    chk("wb_data", s, s_wb[s], q[s][0].wb);
                    chk("out_rd", s, 32'(s_rd[s]), 32'(q[s][0].rd));
                    chk("regwrite", s, 32'(s_rw[s]), 32'(q[s][0].rw));
                end else begin
                    chk("bubble_rw", s, 32'(s_rw[s]), 32'd0);
                end
                if (s_ov[s] && ordy[s] && n > 0) begin
                    void'(q[s].pop_front());
                end
                if (fl[s]) begin
                    q[s].delete();
                end else if (iv[s] && s_ir[s]) begin
                    q[s].push_back(stim[s]);
                end
            end
        end
    end

    task automatic drive(input int s, input logic v, input logic [31:0] a,
                         input logic [31:0] m, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic o,
                         input logic f);
        iv[s]   = v;
        ia[s]   = a;
        im[s]   = m;
        ird[s]  = rd;
        irw[s]  = rw;
        imr[s]  = mr;
        ordy[s] = o;
        fl[s]   = f;
        stim[s] = '{wb: (mr ? m : a), rd: rd, rw: (rw && (rd != 5'd0))};
    endtask

    task automatic both(input logic v, input logic [31:0] a, input logic [31:0] m,
                        input logic [4:0] rd, input logic rw, input logic mr,
                        input logic o, input logic f);
        drive(0, v, a, m, rd, rw, mr, o, f);
        drive(1, v, a, m, rd, rw, mr, o, f);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Stimulus: directed scenarios followed by randomized traffic on both builds.
    initial begin
        rst_n = 1'b0;
        both(1'b1, 32'hDEAD_BEEF, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        step(3);
        rst_n = 1'b1;
        both(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(2);

        for (int i = 1; i <= 8; i++) begin
            both(1'b1, 32'(i), ~32'(i), 5'(i), 1'b1, 1'b0, 1'b1, 1'b0);
            step(1);
        end
        both(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(2);

        both(1'b1, 32'd5, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1);
        both(1'b1, 32'd0, 32'd9, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1);
        both(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(2);
        both(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3);

        both(1'b1, 32'd11, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1);
        both(1'b1, 32'd12, 32'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1);
        both(1'b1, 32'hC0C0, 32'd0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1);
        both(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(2);

        both(1'b1, 32'd7, 32'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1);
        both(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(2);

        both(1'b1, 32'd21, 32'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1);
        both(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1);
        both(1'b1, 32'd22, 32'd0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1);
        both(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(3);

        both(1'b1, 32'd31, 32'd0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1);
        both(1'b1, 32'd32, 32'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1);
        rst_n = 1'b0;
        both(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1);
        rst_n = 1'b1;
        step(2);

        for (int c = 0; c < 800; c++) begin
            for (int s = 0; s < 2; s++) begin
                drive(s, $urandom_range(0, 9) < 7, $urandom, $urandom,
                      5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6,
                      $urandom_range(0, 39) == 0);
            end
            step(1);
        end

        both(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(4);
        @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("drain", s, 32'(q[s].size()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
